// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// Hazard unit for the ID stage of a 16-bit, 5-stage pipeline. It keeps a shadow
// of the EX/MEM/WB destination tags, advanced from the ID-stage controls. From
// that shadow it produces the operand forward selects, the load-use stall, the
// wrong-path kill, and two free-running performance counters.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   id_valid            ID holds a real instruction (0 = bubble)
//   id_rs1, id_rs2      ID source register indices
//   id_use_rs1/2        ID instruction actually reads rs1 / rs2
//   id_rd, id_regwr     ID destination index and register-write enable
//   id_memr             ID instruction is a load
//   id_ctrl_taken       ID resolves a taken branch / jump / For
//   ForwardA/B          operand source: 0 regfile, 1 ALUOut, 2 MemoryOut, 3 WBData
//   stall               hold PC and IF/ID, inject a bubble into EX
//   kill                flush the wrong-path instruction in IF/ID
//   num_stalls          count of cycles with stall high (wraps)
//   num_kills           count of cycles with kill high (wraps)
module hazard_forward_ctrl #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwr,
  input  logic             id_memr,
  input  logic             id_ctrl_taken,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall,
  output logic             kill,
  output logic [CNT_W-1:0] num_stalls,
  output logic [CNT_W-1:0] num_kills
);

  typedef enum logic [0:0] {StRun, StLuWait} state_e;

  state_e state_q, state_d;

  // Shadow tags. Only EX needs memr: a load in MEM or WB forwards like any writer.
  logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_regwr_q, mem_regwr_q, wb_regwr_q;
  logic             ex_memr_q;

  logic [CNT_W-1:0] num_stalls_q, num_kills_q;

  logic lu;
  logic advance;

  // Youngest producer wins. A load still in EX has no data yet, so it is skipped;
  // that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input logic use_src);
    logic [1:0] sel;
    sel = 2'd0;
    if (src == '0 || !use_src) begin
      sel = 2'd0;
    end else if (ex_regwr_q && !ex_memr_q && ex_rd_q == src) begin
      sel = 2'd1;
    end else if (mem_regwr_q && mem_rd_q == src) begin
      sel = 2'd2;
    end else if (wb_regwr_q && wb_rd_q == src) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardA = fwd_sel(id_rs1, id_use_rs1);
    ForwardB = fwd_sel(id_rs2, id_use_rs2);
  end

  always_comb begin
    lu = id_valid && ex_regwr_q && ex_memr_q && (ex_rd_q != '0) &&
         ((id_use_rs1 && id_rs1 == ex_rd_q) || (id_use_rs2 && id_rs2 == ex_rd_q));
  end

  // Stall only from StRun, so a single load never holds ID for more than one cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (lu) begin
          stall   = 1'b1;
          state_d = StLuWait;
        end
      end
      StLuWait: begin
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Gated by reset so kill drops as soon as reset rises, not at the next edge.
  always_comb begin
    kill = id_valid && id_ctrl_taken && !stall && !reset;
  end

  assign advance = id_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      ex_rd_q     <= '0;
      ex_regwr_q  <= 1'b0;
      ex_memr_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_regwr_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_regwr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_rd_q     <= mem_rd_q;
      wb_regwr_q  <= mem_regwr_q;
      mem_rd_q    <= ex_rd_q;
      mem_regwr_q <= ex_regwr_q;
      if (advance) begin
        ex_rd_q    <= id_rd;
        ex_regwr_q <= id_regwr;
        ex_memr_q  <= id_memr;
      end else begin
        ex_rd_q    <= '0;
        ex_regwr_q <= 1'b0;
        ex_memr_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_stalls_q <= '0;
      num_kills_q  <= '0;
    end else begin
      num_stalls_q <= num_stalls_q + {{(CNT_W-1){1'b0}}, stall};
      num_kills_q  <= num_kills_q + {{(CNT_W-1){1'b0}}, kill};
    end
  end

  assign num_stalls = num_stalls_q;
  assign num_kills  = num_kills_q;

endmodule
